// File: rtl/switch_post_sched.sv
// Egress scheduler: arbitrates among NQ queue descriptors, streams each granted
// frame's cells from the shared cell buffer into the post stage, then frees it.
module switch_post_sched #(
  parameter int NQ     = 4,
  parameter int PTR_W  = 10,
  parameter int CNT_W  = 8,
  parameter int RD_LAT = 2
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic                  cfg_strict,
  input  logic [NQ-1:0]         q_req,
  input  logic [NQ*PTR_W-1:0]   q_head_ptr,
  input  logic [NQ*CNT_W-1:0]   q_cell_cnt,
  output logic [NQ-1:0]         q_ack,
  output logic                  mem_rd,
  output logic [PTR_W-1:0]      mem_addr,
  input  logic [127:0]          mem_dout,
  output logic                  o_cell_data_fifo_wr,
  output logic [127:0]          o_cell_data_fifo_din,
  output logic                  o_cell_data_first,
  output logic                  o_cell_data_last,
  input  logic                  o_cell_data_fifo_bp,
  output logic                  free_vld,
  output logic [PTR_W-1:0]      free_ptr,
  output logic [CNT_W-1:0]      free_cnt,
  output logic                  busy
);

  localparam int QW = $clog2(NQ);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, RELEASE} state_t;

  state_t            state, state_nxt;
  logic [QW-1:0]     rr_last;
  logic [PTR_W-1:0]  head_ptr, cur_ptr;
  logic [CNT_W-1:0]  rem, cnt_l;
  logic              first_pend;
  logic [RD_LAT-1:0] pipe_vld, pipe_first, pipe_last;

  logic              win_found;
  logic [QW-1:0]     win_idx;
  logic [PTR_W-1:0]  win_ptr;
  logic [CNT_W-1:0]  win_cnt;
  logic              grant;
  logic              rd_last;

  // Strict: scan from queue 0. Round robin: scan starting just after the last grant.
  always_comb begin : arb
    int            idx;
    logic [QW-1:0] idx_q;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    idx_q     = '0;
    for (int k = 0; k < NQ; k++) begin
      idx   = cfg_strict ? k : (int'(rr_last) + 1 + k) % NQ;
      idx_q = QW'(idx);
      if (!win_found && q_req[idx_q]) begin
        win_found = 1'b1;
        win_idx   = idx_q;
      end
    end
  end

  assign win_ptr = q_head_ptr[win_idx*PTR_W +: PTR_W];
  assign win_cnt = q_cell_cnt[win_idx*CNT_W +: CNT_W];
  assign grant   = (state == IDLE) && win_found && !o_cell_data_fifo_bp;
  assign rd_last = (rem == CNT_W'(1));
  assign busy    = (state != IDLE);

  // NOTE: every output and next-state value gets a default before the case so
  // that no path leaves a signal unassigned, which would otherwise infer a latch.
  always_comb begin
    state_nxt = state;
    q_ack     = '0;
    mem_rd    = 1'b0;
    mem_addr  = '0;
    free_vld  = 1'b0;
    free_ptr  = '0;
    free_cnt  = '0;
    unique case (state)
      IDLE: begin
        if (grant) begin
          q_ack[win_idx] = 1'b1;
          state_nxt      = (win_cnt == '0) ? RELEASE : ISSUE;
        end
      end
      ISSUE: begin
        if (!o_cell_data_fifo_bp) begin
          mem_rd   = 1'b1;
          mem_addr = cur_ptr;
          if (rd_last) state_nxt = DRAIN;
        end
      end
      DRAIN: begin
        if (o_cell_data_fifo_wr && o_cell_data_last && (pipe_vld == '0))
          state_nxt = RELEASE;
      end
      RELEASE: begin
        free_vld  = 1'b1;
        free_ptr  = head_ptr;
        free_cnt  = cnt_l;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state                <= IDLE;
      rr_last              <= QW'(NQ - 1);
      head_ptr             <= '0;
      cur_ptr              <= '0;
      rem                  <= '0;
      cnt_l                <= '0;
      first_pend           <= 1'b0;
      pipe_vld             <= '0;
      pipe_first           <= '0;
      pipe_last            <= '0;
      o_cell_data_fifo_wr  <= 1'b0;
      o_cell_data_fifo_din <= '0;
      o_cell_data_first    <= 1'b0;
      o_cell_data_last     <= 1'b0;
    end else begin
      state <= state_nxt;
      if (grant) begin
        rr_last    <= win_idx;
        head_ptr   <= win_ptr;
        cur_ptr    <= win_ptr;
        rem        <= win_cnt;
        cnt_l      <= win_cnt;
        first_pend <= 1'b1;
      end else if (mem_rd) begin
        cur_ptr    <= cur_ptr + PTR_W'(1);
        rem        <= rem - CNT_W'(1);
        first_pend <= 1'b0;
      end
      // Tag shift register: bit 0 enters with the read, bit RD_LAT-1 lines up with mem_dout.
      pipe_vld   <= RD_LAT'({pipe_vld, mem_rd});
      pipe_first <= RD_LAT'({pipe_first, mem_rd & first_pend});
      pipe_last  <= RD_LAT'({pipe_last, mem_rd & rd_last});
      o_cell_data_fifo_wr  <= pipe_vld[RD_LAT-1];
      o_cell_data_fifo_din <= pipe_vld[RD_LAT-1] ? mem_dout : '0;
      o_cell_data_first    <= pipe_vld[RD_LAT-1] & pipe_first[RD_LAT-1];
      o_cell_data_last     <= pipe_vld[RD_LAT-1] & pipe_last[RD_LAT-1];
    end
  end

endmodule

// File: tb/tb_switch_post_sched.sv
// Bench for switch_post_sched: queue/buffer models around the DUT, a frame-level
// arbitration model, and log-based comparison of grants, reads, cells and frees.
module tb_switch_post_sched;

  localparam int NQ     = 4;
  localparam int PTR_W  = 10;
  localparam int CNT_W  = 8;
  localparam int RD_LAT = 2;
  localparam int DEPTH  = 1 << PTR_W;

  typedef struct packed {logic [PTR_W-1:0] ptr; logic [CNT_W-1:0] cnt;} desc_t;
  typedef struct packed {logic [127:0] data; logic first; logic last;} cell_t;
  typedef struct {logic [PTR_W-1:0] ptr; logic [CNT_W-1:0] cnt; int cells;} free_t;

  logic                 clk = 1'b0;
  logic                 rstn;
  logic                 cfg_strict;
  logic [NQ-1:0]        q_req;
  logic [NQ*PTR_W-1:0]  q_head_ptr;
  logic [NQ*CNT_W-1:0]  q_cell_cnt;
  logic [NQ-1:0]        q_ack;
  logic                 mem_rd;
  logic [PTR_W-1:0]     mem_addr;
  logic [127:0]         mem_dout;
  logic                 o_wr, o_first, o_last, bp;
  logic [127:0]         o_din;
  logic                 free_vld;
  logic [PTR_W-1:0]     free_ptr;
  logic [CNT_W-1:0]     free_cnt;
  logic                 busy;

  switch_post_sched #(.NQ(NQ), .PTR_W(PTR_W), .CNT_W(CNT_W), .RD_LAT(RD_LAT)) dut (
    .clk(clk), .rstn(rstn), .cfg_strict(cfg_strict),
    .q_req(q_req), .q_head_ptr(q_head_ptr), .q_cell_cnt(q_cell_cnt), .q_ack(q_ack),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_dout(mem_dout),
    .o_cell_data_fifo_wr(o_wr), .o_cell_data_fifo_din(o_din),
    .o_cell_data_first(o_first), .o_cell_data_last(o_last),
    .o_cell_data_fifo_bp(bp),
    .free_vld(free_vld), .free_ptr(free_ptr), .free_cnt(free_cnt), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;

  // Cell buffer model with RD_LAT cycles of read latency.
  logic [127:0] mem [DEPTH];
  logic [127:0] rd_pipe [RD_LAT];
  always @(posedge clk) begin
    rd_pipe[0] <= mem_rd ? mem[mem_addr] : '0;
    for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
  end
  assign mem_dout = rd_pipe[RD_LAT-1];

  // Observation logs, sampled on the falling edge.
  int unsigned     cyc = 0;
  logic [PTR_W-1:0] rd_log[$];
  cell_t           wr_log[$];
  int              ack_log[$];
  int unsigned     ack_cyc[$];
  free_t           free_log[$];
  int              rd_during_bp, ack_during_bp, multi_ack;
  logic [NQ-1:0]   ack_sampled = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    ack_sampled = q_ack;
    if (mem_rd) begin
      rd_log.push_back(mem_addr);
      if (bp) rd_during_bp++;
    end
    if (o_wr) wr_log.push_back('{o_din, o_first, o_last});
    if (|q_ack) begin
      if ($countones(q_ack) != 1) multi_ack++;
      if (bp) ack_during_bp++;
      for (int i = 0; i < NQ; i++)
        if (q_ack[i]) begin
          ack_log.push_back(i);
          ack_cyc.push_back(cyc);
        end
    end
    if (free_vld) free_log.push_back('{free_ptr, free_cnt, wr_log.size()});
  end

  // Upstream queues and backpressure driver.
  desc_t qlist [NQ][$];
  int    bp_mode = 0;
  int    bp_left = 0;
  bit    bp_done = 0;
  int    model_last = NQ - 1;
  int    exp_q[$];
  desc_t exp_d[$];

  task automatic drive_inputs();
    for (int i = 0; i < NQ; i++) begin
      q_req[i] = (qlist[i].size() > 0);
      q_head_ptr[i*PTR_W +: PTR_W] = q_req[i] ? qlist[i][0].ptr : '0;
      q_cell_cnt[i*CNT_W +: CNT_W] = q_req[i] ? qlist[i][0].cnt : '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    for (int i = 0; i < NQ; i++)
      if (ack_sampled[i] && qlist[i].size() > 0) void'(qlist[i].pop_front());
    case (bp_mode)
      1: bp = ($urandom_range(0, 3) == 0);
      2: begin
        if (!bp_done && rd_log.size() >= 3) begin
          bp_left = 10;
          bp_done = 1;
        end
        bp = (bp_left > 0);
        if (bp_left > 0) bp_left--;
      end
      default: bp = 1'b0;
    endcase
    drive_inputs();
  endtask

  function automatic bit frames_pending();
    for (int i = 0; i < NQ; i++) if (qlist[i].size() > 0) return 1'b1;
    return 1'b0;
  endfunction

  task automatic clear_logs();
    rd_log.delete(); wr_log.delete(); ack_log.delete(); ack_cyc.delete(); free_log.delete();
    rd_during_bp = 0; ack_during_bp = 0; multi_ack = 0;
  endtask

  // Frame-level reference: serve the loaded queues one frame at a time.
  task automatic build_model(input bit strict);
    desc_t m [NQ][$];
    int w, idx;
    exp_q.delete();
    exp_d.delete();
    for (int i = 0; i < NQ; i++) m[i] = qlist[i];
    do begin
      w = -1;
      for (int k = 0; k < NQ; k++) begin
        idx = strict ? k : (model_last + 1 + k) % NQ;
        if (w < 0 && m[idx].size() > 0) w = idx;
      end
      if (w >= 0) begin
        exp_q.push_back(w);
        exp_d.push_back(m[w].pop_front());
        model_last = w;
      end
    end while (w >= 0);
  endtask

  task automatic run_frames(input string name, input int budget);
    int n = 0;
    drive_inputs();
    while ((busy || frames_pending()) && n < budget) begin
      step();
      n++;
    end
    n_cmp++;
    if (busy || frames_pending()) begin
      n_fail++;
      $display("FAIL %s timeout: busy=%0b pending=%0b after %0d cycles, want idle", name, busy, frames_pending(), n);
    end
  endtask

  task automatic verify_frames(input string name, input bit check_tput);
    logic [PTR_W-1:0] e_rd[$];
    cell_t            e_wr[$];
    logic [PTR_W-1:0] a;
    int bad, cum, gap, want;
    foreach (exp_d[f])
      for (int k = 0; k < int'(exp_d[f].cnt); k++) begin
        a = exp_d[f].ptr + PTR_W'(k);
        e_rd.push_back(a);
        e_wr.push_back('{mem[a], (k == 0), (k == int'(exp_d[f].cnt) - 1)});
      end

    n_cmp++;
    bad = (ack_log.size() != exp_q.size()) ? 0 : -1;
    if (bad < 0) foreach (exp_q[i]) if (bad < 0 && ack_log[i] !== exp_q[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s grant_order: got %p want %p", name, ack_log, exp_q);
    end

    n_cmp++;
    bad = (rd_log.size() != e_rd.size()) ? 0 : -1;
    if (bad < 0) foreach (e_rd[i]) if (bad < 0 && rd_log[i] !== e_rd[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s mem_addr: count %0d want %0d, first bad idx %0d got %h want %h", name,
               rd_log.size(), e_rd.size(), bad, (bad < rd_log.size()) ? rd_log[bad] : '0,
               (bad < e_rd.size()) ? e_rd[bad] : '0);
    end

    n_cmp++;
    bad = (wr_log.size() != e_wr.size()) ? 0 : -1;
    if (bad < 0) foreach (e_wr[i]) if (bad < 0 && wr_log[i] !== e_wr[i]) bad = i;
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s cells: count %0d want %0d, first bad idx %0d got f/l %b%b want f/l %b%b", name,
               wr_log.size(), e_wr.size(), bad,
               (bad < wr_log.size()) ? wr_log[bad].first : 1'b0, (bad < wr_log.size()) ? wr_log[bad].last : 1'b0,
               (bad < e_wr.size()) ? e_wr[bad].first : 1'b0, (bad < e_wr.size()) ? e_wr[bad].last : 1'b0);
    end

    n_cmp++;
    bad = (free_log.size() != exp_d.size()) ? 0 : -1;
    cum = 0;
    if (bad < 0) foreach (exp_d[i]) begin
      cum += int'(exp_d[i].cnt);
      if (bad < 0 && (free_log[i].ptr !== exp_d[i].ptr || free_log[i].cnt !== exp_d[i].cnt ||
                      free_log[i].cells != cum)) bad = i;
    end
    if (bad >= 0) begin
      n_fail++;
      $display("FAIL %s free: count %0d want %0d, first bad idx %0d", name, free_log.size(), exp_d.size(), bad);
      if (bad < free_log.size() && bad < exp_d.size())
        $display("FAIL %s free[%0d]: got ptr %h cnt %0d after %0d cells, want ptr %h cnt %0d", name, bad,
                 free_log[bad].ptr, free_log[bad].cnt, free_log[bad].cells, exp_d[bad].ptr, exp_d[bad].cnt);
    end

    n_cmp++;
    if ((rd_during_bp + ack_during_bp + multi_ack) !== 0) begin
      n_fail++;
      $display("FAIL %s bp_rules: rd_in_bp %0d ack_in_bp %0d multi_ack %0d, want all 0",
               name, rd_during_bp, ack_during_bp, multi_ack);
    end

    if (check_tput && ack_cyc.size() == exp_d.size()) begin
      bad = -1;
      for (int i = 0; i + 1 < ack_cyc.size(); i++) begin
        gap  = int'(ack_cyc[i+1] - ack_cyc[i]);
        want = (exp_d[i].cnt == 0) ? 2 : int'(exp_d[i].cnt) + RD_LAT + 3;
        if (bad < 0 && gap != want) bad = i;
      end
      n_cmp++;
      if (bad >= 0) begin
        n_fail++;
        $display("FAIL %s frame_period: frame %0d got %0d cycles want %0d", name, bad,
                 int'(ack_cyc[bad+1] - ack_cyc[bad]),
                 (exp_d[bad].cnt == 0) ? 2 : int'(exp_d[bad].cnt) + RD_LAT + 3);
      end
    end
  endtask

  task automatic scenario(input string name, input bit strict, input int bpm, input bit tput);
    clear_logs();
    cfg_strict = strict;
    bp_mode    = bpm;
    bp_done    = 0;
    build_model(strict);
    run_frames(name, 4000);
    verify_frames(name, tput);
  endtask

  task automatic test_reset();
    repeat (3) step();
    n_cmp++;
    if ({q_ack, mem_rd, mem_addr, o_wr, o_din, o_first, o_last, free_vld, free_ptr, free_cnt, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs_in_reset: busy=%b mem_rd=%b wr=%b free=%b, want all 0", busy, mem_rd, o_wr, free_vld);
    end
    rstn = 1'b1;
    repeat (3) step();
    n_cmp++;
    if ({q_ack, mem_rd, o_wr, free_vld, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_idle_after_release: busy=%b mem_rd=%b wr=%b free=%b, want all 0", busy, mem_rd, o_wr, free_vld);
    end
  endtask

  task automatic test_rr();
    qlist[0].push_back('{10'h010, 8'd1});
    qlist[0].push_back('{10'h050, 8'd1});
    qlist[1].push_back('{10'h020, 8'd1});
    qlist[2].push_back('{10'h030, 8'd1});
    qlist[3].push_back('{10'h040, 8'd1});
    scenario("rr", 1'b0, 0, 1'b1);
  endtask

  task automatic test_strict();
    qlist[1].push_back('{10'h080, 8'd2});
    qlist[1].push_back('{10'h090, 8'd3});
    qlist[1].push_back('{10'h0A0, 8'd1});
    qlist[3].push_back('{10'h0B0, 8'd2});
    qlist[3].push_back('{10'h0C0, 8'd1});
    scenario("strict", 1'b1, 0, 1'b1);
  endtask

  task automatic test_wrap();
    qlist[2].push_back('{10'h3FE, 8'd4});
    scenario("wrap", 1'b0, 0, 1'b1);
  endtask

  task automatic test_backpressure();
    qlist[3].push_back('{10'h200, 8'd8});
    scenario("backpressure", 1'b0, 2, 1'b0);
  endtask

  task automatic test_zero_cnt();
    qlist[0].push_back('{10'h155, 8'd0});
    qlist[2].push_back('{10'h077, 8'd0});
    qlist[3].push_back('{10'h060, 8'd1});
    scenario("zero_cnt", 1'b0, 0, 1'b1);
  endtask

  task automatic test_random(input bit strict);
    for (int f = 0; f < 12; f++)
      qlist[$urandom_range(0, NQ-1)].push_back('{PTR_W'($urandom), CNT_W'($urandom_range(0, 12))});
    scenario(strict ? "random_strict" : "random_rr", strict, 1, 1'b0);
  endtask

  task automatic test_back_to_back();
    for (int f = 0; f < 8; f++)
      qlist[f % NQ].push_back('{PTR_W'($urandom), CNT_W'($urandom_range(1, 6))});
    scenario("back_to_back", 1'b0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    int n = 0;
    clear_logs();
    cfg_strict = 1'b0;
    bp_mode    = 0;
    qlist[2].push_back('{10'h100, 8'd6});
    drive_inputs();
    while (rd_log.size() < 2 && n < 50) begin
      step();
      n++;
    end
    n_cmp++;
    if (rd_log.size() < 2) begin
      n_fail++;
      $display("FAIL reset_mid_start: got %0d reads, want >= 2", rd_log.size());
    end
    rstn = 1'b0;
    for (int i = 0; i < NQ; i++) qlist[i].delete();
    drive_inputs();
    #1;
    n_cmp++;
    if ({q_ack, mem_rd, mem_addr, o_wr, o_din, o_first, o_last, free_vld, free_ptr, free_cnt, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_mid_outputs: busy=%b mem_rd=%b wr=%b free=%b, want all 0", busy, mem_rd, o_wr, free_vld);
    end
    model_last = NQ - 1;
    repeat (4) step();
    n_cmp++;
    if (free_log.size() != 0 || wr_log.size() != 0) begin
      n_fail++;
      $display("FAIL reset_mid_abort: got %0d frees %0d cells, want 0 and 0", free_log.size(), wr_log.size());
    end
    rstn = 1'b1;
    step();
    for (int i = NQ - 1; i >= 0; i--) qlist[i].push_back('{PTR_W'(16 * i + 8), 8'd1});
    scenario("after_reset", 1'b0, 0, 1'b1);
    n_cmp++;
    if (ack_log.size() == 0 || ack_log[0] !== 0) begin
      n_fail++;
      $display("FAIL after_reset_first_grant: got %0d, want 0", (ack_log.size() > 0) ? ack_log[0] : -1);
    end
  endtask

  initial begin
    rstn       = 1'b0;
    cfg_strict = 1'b0;
    bp         = 1'b0;
    q_req      = '0;
    q_head_ptr = '0;
    q_cell_cnt = '0;
    for (int i = 0; i < DEPTH; i++) mem[i] = {$urandom, $urandom, $urandom, $urandom};
    test_reset();
    test_rr();
    test_strict();
    test_wrap();
    test_backpressure();
    test_zero_cnt();
    test_back_to_back();
    test_random(1'b0);
    test_random(1'b1);
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
